reg_stream_ctrl: RTL and testbench
==================================

Name: reg_stream_ctrl

Overview:
- Parametrised successor to the single-instruct-bus register controller.
- Accepts command and data words on a valid/ready input stream.
- Serialises register-file reads onto a valid/ready output stream; deserialises write data into one-hot register write pulses.
- Sits between the host word interface and the `main` register datapath. Per-register word counts come from a parameter table, not hard-coded cases.

Parameters:
- WORD_W, 32, host word width; command flag is bit WORD_W-1.
- DATA_W, 256, register width; must be a multiple of WORD_W.
- NUM_REGS, 16, number of datapath registers.
- ADDR_W, 4, register index width; must satisfy 2^ADDR_W >= NUM_REGS.
- LEN_W, 4, width of each length-table entry.
- LEN_TABLE, 64'h1555_1144_1888_1444, NUM_REGS×LEN_W packed word counts; register 0 is in the LSBs.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, host word valid.
- in_ready, output, 1, controller accepts host word.
- in_data, input, WORD_W, command or write-data word.
- out_valid, output, 1, read word valid.
- out_ready, input, 1, host accepts read word.
- out_data, output, WORD_W, read word.
- out_last, output, 1, final word of the current read.
- busy, output, 1, high in any state other than IDLE.
- reg_rd_sel, output, ADDR_W, datapath read select (registered).
- reg_rd_data, input, DATA_W, datapath read data; valid one cycle after reg_rd_sel changes.
- reg_wr_en, output, NUM_REGS, one-hot write strobe.
- reg_wr_data, output, DATA_W, write data bus.

Behaviour:
- Reset values:
  - State returns to IDLE.
  - All outputs are 0, except in_ready = 1.
  - Word counter and buffers are cleared.
  - A reset arriving mid-command drops the command; no reg_wr_en pulse is produced afterwards.
- Handshake: a transfer occurs when valid && ready on a rising edge. While out_valid=1 and out_ready=0, out_data and out_last must hold stable.
- Command word: captured in IDLE on in_valid && in_ready.
  - in_data[WORD_W-1]: 0 = read, 1 = write.
  - in_data[ADDR_W-1:0]: register index idx.
  - Word count n = LEN_TABLE[idx]. An entry of 0 is treated as 1. Entries above DATA_W/WORD_W are clamped to DATA_W/WORD_W.
- States:
  - IDLE: in_ready=1.
    - Read command → RD_WAIT, with reg_rd_sel <= idx.
    - Write command → WR_COLLECT, with counter=0 and the write buffer zeroed.
  - RD_WAIT: one cycle; in_ready=0. At the end of the cycle, snapshot reg_rd_data into the shift buffer and go to RD_STREAM. The snapshot prevents tearing by later writes.
  - RD_STREAM: out_valid=1 and out_data = buffer word[counter], lowest word first. out_last=1 when counter==n-1.
    - Each accepted word increments counter.
    - Acceptance of the last word → IDLE; out_valid falls in the following cycle.
  - WR_COLLECT: in_ready=1. Each accepted word is stored at word[counter]; counter increments. Words above n stay 0.
    - Acceptance of word n-1 → WR_COMMIT.
  - WR_COMMIT: one cycle.
    - reg_wr_en = 1 << idx and reg_wr_data = buffer.
    - in_ready=0.
    - Next state is IDLE; reg_wr_en returns to 0.
- Latency:
  - Read: command accepted in cycle t → out_valid=1 in cycle t+2 (one RD_WAIT cycle).
  - Write: last data word accepted in cycle t → reg_wr_en high during cycle t+1 only.
  - Minimum command-to-command gap is 0 cycles after IDLE is re-entered.
- in_data presented during RD_WAIT, RD_STREAM or WR_COMMIT is not accepted (in_ready=0).
- reg_wr_en is never multi-hot. For idx >= NUM_REGS, no strobe is produced.

Optional Feature:
- Macro: REG_STREAM_CTRL_ERR_EN.
- When defined:
  - Adds output `err` (1 bit, reset 0).
  - A command is illegal if in_data[WORD_W-2:ADDR_W] is nonzero or idx >= NUM_REGS.
  - An illegal command is consumed in IDLE. err pulses high for one cycle, no read or write occurs, and the state stays IDLE.
- When undefined:
  - The reserved bits are ignored.
  - idx >= NUM_REGS reads stream n zero words.
  - idx >= NUM_REGS writes collect n words and produce no reg_wr_en pulse.

Test Plan:
1. Read reg 4 (in_data=32'h0000_0004) with reg_rd_data=256'h{8 words 8..1} and out_ready held 1 → out_valid rises 2 cycles after acceptance. out_data=1,2,...,8 on consecutive cycles; out_last=1 only with 8.
2. Write reg 12: command 32'h8000_000C, then 5 words A0..A4 → reg_wr_en=16'h1000 for exactly one cycle. reg_wr_data[159:0]={A4..A0} and the upper 96 bits = 0.
3. Read reg 3 (length 1) with out_ready low for 3 cycles → out_data and out_last=1 stable throughout. The word transfers when out_ready rises, then IDLE; in_ready=0 until the transfer.
4. Reset asserted after the 2nd word of a reg-0 write → next cycle: state IDLE, in_ready=1, no reg_wr_en pulse ever, busy=0.
5. Back-to-back: a write to reg 0 (4 words) immediately followed by a read of reg 0 → the read stream returns exactly the 4 written words.
6. ERR_EN defined: command 32'h0000_0104 → err=1 for one cycle, no out_valid, no reg_wr_en, in_ready stays 1.

Source files
------------

// File: rtl/reg_stream_ctrl.sv
// Host word stream to register datapath bridge: serialises register reads, deserialises writes.
// Optional macro REG_STREAM_CTRL_ERR_EN adds the err output and rejects illegal commands.
module reg_stream_ctrl #(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned LEN_W    = 4,
    parameter logic [NUM_REGS*LEN_W-1:0] LEN_TABLE = 64'h1555_1144_1888_1444
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_last,
    output logic                busy,
`ifdef REG_STREAM_CTRL_ERR_EN
    output logic                err,
`endif
    output logic [ADDR_W-1:0]   reg_rd_sel,
    input  logic [DATA_W-1:0]   reg_rd_data,
    output logic [NUM_REGS-1:0] reg_wr_en,
    output logic [DATA_W-1:0]   reg_wr_data
);

    localparam int unsigned NWORDS = DATA_W / WORD_W;
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_STREAM,
        S_WR_COLLECT,
        S_WR_COMMIT
    } state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [CNT_W-1:0]                 last_q, last_d;
    logic [ADDR_W-1:0]                idx_q, idx_d;
    logic [ADDR_W-1:0]                rd_sel_q, rd_sel_d;
    logic [NWORDS-1:0][WORD_W-1:0]    buf_q, buf_d;
    logic [WORD_W-1:0]                out_data_q, out_data_d;
    logic                             out_last_q, out_last_d;
    logic                             out_valid_q, out_valid_d;
    logic                             in_ready_q, in_ready_d;
    logic                             busy_q, busy_d;
    logic [NUM_REGS-1:0]              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]                cmd_idx;
    logic                             cmd_illegal;

    // Table entry for a register as a last-word index; 0 means one word, oversize clamps to a full register.
    function automatic logic [CNT_W-1:0] len_m1(input logic [ADDR_W-1:0] idx);
        int unsigned ln;
        ln = 1;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (int'(idx) == i) ln = 32'(LEN_TABLE[i*LEN_W +: LEN_W]);
        end
        if (ln == 0) ln = 1;
        if (ln > NWORDS) ln = NWORDS;
        return CNT_W'(ln - 1);
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    assign cmd_idx = in_data[ADDR_W-1:0];

`ifdef REG_STREAM_CTRL_ERR_EN
    logic err_q, err_d;
    assign cmd_illegal = (|in_data[WORD_W-2:ADDR_W]) || !in_range(cmd_idx);
    assign err         = err_q;
`else
    logic unused_rsvd;
    assign unused_rsvd = ^in_data[WORD_W-2:ADDR_W];
    assign cmd_illegal = 1'b0;
`endif

    // Next state and next output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        idx_d      = idx_q;
        rd_sel_d   = rd_sel_q;
        buf_d      = buf_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        wr_en_d    = '0;
`ifdef REG_STREAM_CTRL_ERR_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (cmd_illegal) begin
`ifdef REG_STREAM_CTRL_ERR_EN
                        err_d = 1'b1;
`endif
                    end else begin
                        idx_d  = cmd_idx;
                        last_d = len_m1(cmd_idx);
                        cnt_d  = '0;
                        if (in_data[WORD_W-1]) begin
                            state_d = S_WR_COLLECT;
                            buf_d   = '0;
                        end else begin
                            state_d  = S_RD_WAIT;
                            rd_sel_d = cmd_idx;
                        end
                    end
                end
            end
            S_RD_WAIT: begin
                // Snapshot so later writes cannot tear an in-flight read
                buf_d      = in_range(rd_sel_q) ? reg_rd_data : '0;
                state_d    = S_RD_STREAM;
                cnt_d      = '0;
                out_data_d = buf_d[0];
                out_last_d = (last_q == '0);
            end
            S_RD_STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (cnt_q == last_q) begin
                        state_d    = S_IDLE;
                        out_last_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        out_data_d = buf_q[cnt_d];
                        out_last_d = (cnt_d == last_q);
                    end
                end
            end
            S_WR_COLLECT: begin
                if (in_valid && in_ready_q) begin
                    buf_d[cnt_q] = in_data;
                    if (cnt_q == last_q) begin
                        state_d = S_WR_COMMIT;
                        if (in_range(idx_q)) wr_en_d = NUM_REGS'(1) << idx_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WR_COMMIT: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE) || (state_d == S_WR_COLLECT);
        out_valid_d = (state_d == S_RD_STREAM);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            idx_q       <= '0;
            rd_sel_q    <= '0;
            buf_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            wr_en_q     <= '0;
`ifdef REG_STREAM_CTRL_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            rd_sel_q    <= rd_sel_d;
            buf_q       <= buf_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
`ifdef REG_STREAM_CTRL_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign reg_rd_sel  = rd_sel_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_data = buf_q;

endmodule

// File: tb/tb_reg_stream_ctrl.sv
// Directed bench for reg_stream_ctrl: queue-based expectation model plus literal spot checks.
module tb_reg_stream_ctrl;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned DATA_W   = 256;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam logic [63:0] LEN_TABLE = 64'h1555_1144_1888_1444;

    logic                clock = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [WORD_W-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_data;
    logic                out_last;
    logic                busy;
`ifdef REG_STREAM_CTRL_ERR_EN
    logic                err;
`endif
    logic [ADDR_W-1:0]   reg_rd_sel;
    logic [DATA_W-1:0]   reg_rd_data;
    logic [NUM_REGS-1:0] reg_wr_en;
    logic [DATA_W-1:0]   reg_wr_data;

    reg_stream_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
`ifdef REG_STREAM_CTRL_ERR_EN
        .err         (err),
`endif
        .reg_rd_sel  (reg_rd_sel),
        .reg_rd_data (reg_rd_data),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data)
    );

    always #5 clock = ~clock;

    function automatic logic [255:0] init_val(input int r);
        logic [255:0] v;
        for (int w = 0; w < 8; w++) begin
            if (r == 4) v[w*32 +: 32] = 32'(w + 1);
            else        v[w*32 +: 32] = 32'hC000_0000 | (32'(r) << 16) | 32'(w);
        end
        return v;
    endfunction

    // Stand-in register datapath
    logic [255:0] dp_regs [NUM_REGS];
    logic         dp_inited = 1'b0;
    always @(posedge clock) begin
        if (!dp_inited) begin
            for (int r = 0; r < 16; r++) dp_regs[r] <= init_val(r);
            dp_inited <= 1'b1;
        end else begin
            for (int r = 0; r < 16; r++) if (reg_wr_en[r]) dp_regs[r] <= reg_wr_data;
        end
    end
    assign reg_rd_data = dp_regs[reg_rd_sel];

    typedef struct packed { logic [31:0] data; logic last; } rd_exp_t;
    typedef struct packed { logic [15:0] en; logic [255:0] data; } wr_exp_t;

    rd_exp_t      exp_rd [$];
    wr_exp_t      exp_wr [$];
    logic [255:0] mdl_regs [NUM_REGS];
    int           checks   = 0;
    int           failures = 0;
    logic         prev_stall = 1'b0;
    logic [31:0]  prev_data  = '0;
    logic         prev_last  = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int mlen(input int idx);
        logic [63:0] tbl;
        int v;
        tbl = LEN_TABLE >> (idx * 4);
        v = int'(tbl[3:0]);
        if (v == 0) v = 1;
        if (v > 8) v = 8;
        return v;
    endfunction

    // Per-cycle comparison of DUT outputs against the expectation queues
    task automatic monitor();
        rd_exp_t er;
        wr_exp_t ew;
        if (reset) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("hold_valid", 256'(out_valid), 256'(1'b1));
            check("hold_data", 256'(out_data), 256'(prev_data));
            check("hold_last", 256'(out_last), 256'(prev_last));
        end
        if (out_valid && out_ready) begin
            checks++;
            if (exp_rd.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: word %0h with nothing expected", out_data);
            end else begin
                er = exp_rd.pop_front();
                check("rd_data", 256'(out_data), 256'(er.data));
                check("rd_last", 256'(out_last), 256'(er.last));
            end
        end
        if (reg_wr_en != '0) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: strobe %0h with nothing expected", reg_wr_en);
            end else begin
                ew = exp_wr.pop_front();
                check("wr_en", 256'(reg_wr_en), 256'(ew.en));
                check("wr_data", reg_wr_data, ew.data);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    task automatic tick();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input string nm);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && g < 20) begin
            tick();
            g++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: in_ready got 0 expected 1", nm);
        end
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic issue_read(input logic [31:0] cmd);
        int idx, n;
        rd_exp_t e;
        idx = int'(cmd[3:0]);
        n   = mlen(idx);
        for (int w = 0; w < n; w++) begin
            e.data = mdl_regs[idx][w*32 +: 32];
            e.last = (w == n - 1);
            exp_rd.push_back(e);
        end
        send_word(cmd, "rd_cmd");
    endtask

    task automatic issue_write(input logic [31:0] cmd, input logic [31:0] base);
        int idx, n;
        wr_exp_t e;
        logic [255:0] v;
        idx = int'(cmd[3:0]);
        n   = mlen(idx);
        v   = '0;
        send_word(cmd, "wr_cmd");
        for (int w = 0; w < n; w++) begin
            send_word(base + 32'(w), "wr_data");
            v[w*32 +: 32] = base + 32'(w);
        end
        e.en   = 16'(1) << idx;
        e.data = v;
        exp_wr.push_back(e);
        mdl_regs[idx] = v;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int r = 0; r < 16; r++) mdl_regs[r] = init_val(r);
        repeat (3) tick();
        reset = 1'b0;

        check("rst_in_ready", 256'(in_ready), 256'(1'b1));
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check("rst_out_last", 256'(out_last), 256'(1'b0));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_wr_en", 256'(reg_wr_en), 256'(0));
        check("rst_rd_sel", 256'(reg_rd_sel), 256'(0));
        check("rst_wr_data", reg_wr_data, 256'(0));

        // Read reg 4: eight words 1..8, out_valid two cycles after acceptance
        issue_read(32'h0000_0004);
        check("t1_wait_valid", 256'(out_valid), 256'(1'b0));
        check("t1_wait_in_ready", 256'(in_ready), 256'(1'b0));
        check("t1_wait_busy", 256'(busy), 256'(1'b1));
        tick();
        check("t1_first_valid", 256'(out_valid), 256'(1'b1));
        check("t1_first_data", 256'(out_data), 256'(32'h1));
        repeat (7) tick();
        check("t1_last_data", 256'(out_data), 256'(32'h8));
        check("t1_last_flag", 256'(out_last), 256'(1'b1));
        tick();
        check("t1_end_valid", 256'(out_valid), 256'(1'b0));
        check("t1_end_in_ready", 256'(in_ready), 256'(1'b1));

        // Write reg 12: five words, single strobe 16'h1000
        issue_write(32'h8000_000C, 32'h0000_00A0);
        check("t2_wr_en", 256'(reg_wr_en), 256'(16'h1000));
        check("t2_wr_data", reg_wr_data,
              256'h000000A4_000000A3_000000A2_000000A1_000000A0);
        check("t2_commit_in_ready", 256'(in_ready), 256'(1'b0));
        tick();
        check("t2_wr_en_off", 256'(reg_wr_en), 256'(0));
        check("t2_idle_in_ready", 256'(in_ready), 256'(1'b1));

        // Read reg 3 (one word) with out_ready low for three cycles
        out_ready = 1'b0;
        issue_read(32'h0000_0003);
        tick();
        check("t3_valid", 256'(out_valid), 256'(1'b1));
        check("t3_data", 256'(out_data), 256'(32'hC003_0000));
        check("t3_last", 256'(out_last), 256'(1'b1));
        repeat (3) begin
            tick();
            check("t3_stall_data", 256'(out_data), 256'(32'hC003_0000));
            check("t3_stall_in_ready", 256'(in_ready), 256'(1'b0));
        end
        out_ready = 1'b1;
        tick();
        check("t3_end_valid", 256'(out_valid), 256'(1'b0));
        check("t3_end_in_ready", 256'(in_ready), 256'(1'b1));
        check("t3_end_busy", 256'(busy), 256'(1'b0));

        // Reset in the middle of a reg-0 write: command must be dropped
        send_word(32'h8000_0000, "t4_cmd");
        send_word(32'h7700_0000, "t4_w0");
        send_word(32'h7700_0001, "t4_w1");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_in_ready", 256'(in_ready), 256'(1'b1));
        check("t4_busy", 256'(busy), 256'(1'b0));
        check("t4_wr_en", 256'(reg_wr_en), 256'(0));
        repeat (6) tick();

        // Back-to-back write then read of reg 0
        issue_write(32'h8000_0000, 32'h5000_0000);
        issue_read(32'h0000_0000);
        tick();
        check("t5_first_data", 256'(out_data), 256'(32'h5000_0000));
        repeat (4) tick();
        check("t5_end_valid", 256'(out_valid), 256'(1'b0));

`ifdef REG_STREAM_CTRL_ERR_EN
        // Reserved bits set: consumed with a one-cycle err pulse
        send_word(32'h0000_0104, "t6_cmd");
        check("t6_err", 256'(err), 256'(1'b1));
        check("t6_in_ready", 256'(in_ready), 256'(1'b1));
        check("t6_busy", 256'(busy), 256'(1'b0));
        tick();
        check("t6_err_off", 256'(err), 256'(1'b0));
        repeat (3) begin
            tick();
            check("t6_no_valid", 256'(out_valid), 256'(1'b0));
        end
`else
        // Reserved bits ignored: behaves as a read of reg 4
        issue_read(32'h0000_0104);
        tick();
        check("t6_first_data", 256'(out_data), 256'(32'h1));
        repeat (9) tick();
`endif

        repeat (3) tick();
        check("rd_queue_empty", 256'(exp_rd.size()), 256'(0));
        check("wr_queue_empty", 256'(exp_wr.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
